// File: rtl/demux_lane_deserializer.sv
// demux_lane_deserializer
// Consumes the four outputs of a 1-to-4 bit demultiplexer and rebuilds four
// interleaved serial channels into WIDTH-bit parallel words (first bit
// received lands in the MSB). Completed words leave through a single-entry
// valid/ready register tagged with their lane number. A word that completes
// while the register is held and not being consumed is dropped and flagged
// on the sticky overflow output.
//
// Optional feature: define LANE_PARITY_EN to add the out_parity port, the
// XOR reduction of the word, registered alongside out_data.
module demux_lane_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             S1,
  input  logic             S0,
  input  logic             Y0,
  input  logic             Y1,
  input  logic             Y2,
  input  logic             Y3,
  input  logic             out_ready,
  input  logic             ovf_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_lane,
  output logic             overflow
`ifdef LANE_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  // Bit counter just needs to reach WIDTH-1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // Each lane only keeps the WIDTH-1 bits received so far; the last bit of a
  // word comes straight from the demux input when the word completes.
  logic [WIDTH-2:0] sr_q  [4];
  logic [WIDTH-2:0] sr_d  [4];
  logic [CW-1:0]    cnt_q [4];
  logic [CW-1:0]    cnt_d [4];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [1:0]       out_lane_q,  out_lane_d;
  logic             overflow_q,  overflow_d;
`ifdef LANE_PARITY_EN
  logic             out_parity_q, out_parity_d;
`endif

  logic [1:0]       lane;
  logic             y_bit;
  logic [WIDTH-1:0] word_new;
  logic             complete;
  logic             can_load;
  logic             drop;

  // Pick the demux output that the current select actually drives.
  always_comb begin
    lane = {S1, S0};
    unique case (lane)
      2'd0:    y_bit = Y0;
      2'd1:    y_bit = Y1;
      2'd2:    y_bit = Y2;
      default: y_bit = Y3;
    endcase
  end

  // Lane shift/count update and output-register next-state decision.
  always_comb begin
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_lane_d   = out_lane_q;
    overflow_d   = overflow_q;
`ifdef LANE_PARITY_EN
    out_parity_d = out_parity_q;
`endif

    word_new = {sr_q[lane], y_bit};
    complete = in_valid && (cnt_q[lane] == CNT_LAST);
    // The slot is usable if empty or if its current word leaves this edge.
    can_load = !out_valid_q || out_ready;
    drop     = complete && !can_load;

    if (in_valid) begin
      sr_d[lane]  = word_new[WIDTH-2:0];
      cnt_d[lane] = complete ? '0 : cnt_q[lane] + 1'b1;
    end

    if (complete && can_load) begin
      out_valid_d  = 1'b1;
      out_data_d   = word_new;
      out_lane_d   = lane;
`ifdef LANE_PARITY_EN
      out_parity_d = ^word_new;
`endif
    end else if (out_valid_q && out_ready) begin
      // Consumed with nothing new: data/lane keep their last values.
      out_valid_d = 1'b0;
    end

    // Clear first so that a drop at the same edge wins.
    if (ovf_clr) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  // State registers; reset discards any partially assembled words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        sr_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_lane_q   <= '0;
      overflow_q   <= 1'b0;
`ifdef LANE_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < 4; i++) begin
        sr_q[i]  <= sr_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_lane_q   <= out_lane_d;
      overflow_q   <= overflow_d;
`ifdef LANE_PARITY_EN
      out_parity_q <= out_parity_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_lane   = out_lane_q;
  assign overflow   = overflow_q;
`ifdef LANE_PARITY_EN
  assign out_parity = out_parity_q;
`endif

endmodule
